// File: rtl/lza_pipe_ctrl.sv
// Leading-zero anticipator controller: normalisation shift, sign and zero flag for |A - B|.
// Latency: 3 cycles from acceptance to out_valid; one operation per cycle sustained.
// Backpressure: one global advance (!out_valid || out_ready) freezes all stages; in_ready follows it.
module lza_pipe_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int TAG_WIDTH  = 4,
  parameter int LZ_WIDTH   = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LZ_WIDTH-1:0]   out_lz,
  output logic                  out_sign,
  output logic                  out_zero,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  busy
);

  // S1 payload: per-bit equal / greater / smaller classification of A against B.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] e;
    logic [DATA_WIDTH-1:0] g;
    logic [DATA_WIDTH-1:0] s;
    logic [TAG_WIDTH-1:0]  tag;
  } s1_t;

  // S2 payload: the indicator string for the chosen sign plus its correction vector.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] str;
    logic [DATA_WIDTH-1:0] corr;
    logic                  sign;
    logic                  zero;
    logic [TAG_WIDTH-1:0]  tag;
  } s2_t;

  // S3 payload: the result presented downstream.
  typedef struct packed {
    logic [LZ_WIDTH-1:0]  lz;
    logic                 sign;
    logic                 zero;
    logic [TAG_WIDTH-1:0] tag;
  } s3_t;

  logic s1_vld, s2_vld, s3_vld;
  logic adv, accept;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  s3_t  s3_q, s3_d;

  // lt[i] / gt[i]: the highest non-equal bit strictly below position i is an s / g digit.
  logic [DATA_WIDTH:0]   lt, gt;
  logic [DATA_WIDTH-1:0] pos_str, neg_str;
  logic [LZ_WIDTH-1:0]   pred_lz;
  logic                  corr_hit;

  // Handshake: all stages move together; nothing enters during flush or reset.
  always_comb begin
    adv      = !s3_vld || out_ready;
    in_ready = adv && !flush && !rst;
    accept   = in_valid && in_ready;
  end

  // S1 input decode into e/g/s digit classes.
  always_comb begin
    s1_d     = '0;
    s1_d.e   = ~(in_a ^ in_b);
    s1_d.g   = in_a & ~in_b;
    s1_d.s   = ~in_a & in_b;
    s1_d.tag = in_tag;
  end

  // S2 pre-encoding. For A > B the leading digit of A - B sits at the highest
  // non-equal bit whose lower neighbour is not an s (end of the g s* run);
  // the neg string is the mirror with g and s swapped. The true leading one is
  // at that position or one below it, and it is one below exactly when the
  // remainder underneath is negative, i.e. the first non-equal bit further down
  // is of the opposite class. lt/gt carry that fact for every position.
  always_comb begin
    lt      = '0;
    gt      = '0;
    pos_str = '0;
    neg_str = '0;
    s2_d    = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      lt[i+1] = s1_q.s[i] | (s1_q.e[i] & lt[i]);
      gt[i+1] = s1_q.g[i] | (s1_q.e[i] & gt[i]);
    end
    pos_str[0] = ~s1_q.e[0];
    neg_str[0] = ~s1_q.e[0];
    for (int i = 1; i < DATA_WIDTH; i++) begin
      pos_str[i] = ~s1_q.e[i] & ~s1_q.s[i-1];
      neg_str[i] = ~s1_q.e[i] & ~s1_q.g[i-1];
    end
    s2_d.sign = lt[DATA_WIDTH];
    s2_d.zero = &s1_q.e;
    s2_d.str  = s2_d.sign ? neg_str : pos_str;
    s2_d.corr = s2_d.sign ? gt[DATA_WIDTH-1:0] : lt[DATA_WIDTH-1:0];
    s2_d.tag  = s1_q.tag;
  end

  // S3 leading-digit detection on the selected string, then one-position correction.
  always_comb begin
    pred_lz  = LZ_WIDTH'(DATA_WIDTH);
    corr_hit = 1'b0;
    s3_d     = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (s2_q.str[i]) begin
        pred_lz  = LZ_WIDTH'(DATA_WIDTH - 1 - i);
        corr_hit = s2_q.corr[i];
      end
    end
    s3_d.lz   = pred_lz + LZ_WIDTH'(corr_hit);
    s3_d.sign = s2_q.sign;
    s3_d.zero = s2_q.zero;
    s3_d.tag  = s2_q.tag;
    if (s2_q.zero) begin
      s3_d.lz   = LZ_WIDTH'(DATA_WIDTH);
      s3_d.sign = 1'b0;
    end
  end

  // Stage valid bits: reset and flush empty the pipe, otherwise shift on advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s3_vld <= 1'b0;
    end else if (flush) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s3_vld <= 1'b0;
    end else if (adv) begin
      s1_vld <= accept;
      s2_vld <= s1_vld;
      s3_vld <= s2_vld;
    end
  end

  // Stage payloads load only behind a valid source so the output holds its last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else if (adv && !flush) begin
      if (accept) s1_q <= s1_d;
      if (s1_vld) s2_q <= s2_d;
      if (s2_vld) s3_q <= s3_d;
    end
  end

  assign out_valid = s3_vld;
  assign out_lz    = s3_q.lz;
  assign out_sign  = s3_q.sign;
  assign out_zero  = s3_q.zero;
  assign out_tag   = s3_q.tag;
  assign busy      = s1_vld | s2_vld | s3_vld;

  // A stalled result must still be offered on the following cycle.
  a_stall_hold: assert property (@(posedge clk) disable iff (rst || flush)
    (out_valid && !out_ready) |=> out_valid);

endmodule

// File: tb/tb_lza_pipe_ctrl.sv
// Directed and random checks of lza_pipe_ctrl against an arithmetic |A - B| model.
module tb_lza_pipe_ctrl;
  localparam int W  = 8;
  localparam int TW = 4;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [LW-1:0] out_lz;
  logic          out_sign;
  logic          out_zero;
  logic [TW-1:0] out_tag;
  logic          busy;

  lza_pipe_ctrl #(.DATA_WIDTH(W), .TAG_WIDTH(TW), .LZ_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_lz(out_lz),
    .out_sign(out_sign), .out_zero(out_zero), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lz;
    int sign;
    int zero;
    int tag;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_push = 0;
  int   n_pop = 0;
  bit   rst_d = 1'b0;
  bit   stall_d = 1'b0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Reference: magnitude of the difference and a plain leading-zero count.
  function automatic exp_t model(input int a, input int b, input int tag);
    exp_t r;
    int   d;
    int   n;
    bit   found;
    d = (a >= b) ? a - b : b - a;
    n = 0;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && ((d >> i) & 1) == 1) found = 1'b1;
      if (!found) n++;
    end
    r.lz   = n;
    r.sign = (a < b) ? 1 : 0;
    r.zero = (a == b) ? 1 : 0;
    r.tag  = tag;
    return r;
  endfunction

  // Cycle-by-cycle compare against the ordered expectation queue.
  initial begin : cmp
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        rst_d   = 1'b1;
        stall_d = 1'b0;
      end else begin
        if (rst_d) begin
          chk("rst_out_valid", int'(out_valid), 0);
          chk("rst_busy", int'(busy), 0);
          chk("rst_out_lz", int'(out_lz), 0);
          chk("rst_out_sign", int'(out_sign), 0);
          chk("rst_out_zero", int'(out_zero), 0);
          chk("rst_out_tag", int'(out_tag), 0);
          chk("rst_in_ready", int'(in_ready), flush ? 0 : 1);
        end
        chk("in_ready", int'(in_ready), int'((!out_valid || out_ready) && !flush));
        chk("busy", int'(busy), (q.size() != 0) ? 1 : 0);
        if (stall_d) chk("stall_hold_valid", int'(out_valid), 1);
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_result_queue_depth", q.size(), 1);
          end else begin
            e = q[0];
            chk("out_lz", int'(out_lz), e.lz);
            chk("out_sign", int'(out_sign), e.sign);
            chk("out_zero", int'(out_zero), e.zero);
            chk("out_tag", int'(out_tag), e.tag);
            if (out_ready) begin
              void'(q.pop_front());
              n_pop++;
            end
          end
        end
        if (flush) q.delete();
        else if (in_valid && in_ready) begin
          q.push_back(model(int'(in_a), int'(in_b), int'(in_tag)));
          n_push++;
        end
        stall_d = out_valid && !out_ready && !flush;
        rst_d   = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Present one pair and hold it until accepted; returns just after the accept edge.
  task automatic put(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tag);
    int g;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) chk("accept_timeout", g, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Single operation into an empty pipe with hand-computed expectations and latency.
  task automatic send_chk(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tag,
                          input int lz, input int sign, input int zero);
    int cnt;
    put(a, b, tag);
    cnt = 1;
    while (!out_valid && cnt < 10) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("lit_latency", cnt, 3);
    chk("lit_lz", int'(out_lz), lz);
    chk("lit_sign", int'(out_sign), sign);
    chk("lit_zero", int'(out_zero), zero);
    chk("lit_tag", int'(out_tag), int'(tag));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : stim
    int g;
    int acc_cnt;
    bit acc;
    int mode;

    idle(2);
    rst = 1'b0;
    idle(2);

    // Directed literals.
    send_chk(8'h80, 8'h01, 4'h3, 1, 0, 0);
    send_chk(8'h01, 8'h80, 4'h4, 1, 1, 0);
    send_chk(8'h40, 8'h3F, 4'h5, 7, 0, 0);
    send_chk(8'h5A, 8'h5A, 4'h6, 8, 0, 1);
    send_chk(8'hFF, 8'h00, 4'h7, 0, 0, 0);
    send_chk(8'h00, 8'h01, 4'h8, 7, 1, 0);
    send_chk(8'h10, 8'h0F, 4'h9, 7, 0, 0);
    send_chk(8'h90, 8'h08, 4'h1, 0, 0, 0);
    idle(2);

    // Six back-to-back pairs, four-cycle stall when the first result appears.
    fork
      begin
        for (int k = 0; k < 6; k++) put(8'(k * 16 + 3), 8'(k), 4'(k));
      end
      begin
        g = 0;
        do begin
          @(posedge clk);
          #1;
          g++;
        end while (!out_valid && g < 20);
        chk("stream_first_seen", int'(out_valid), 1);
        out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          chk("stall_valid", int'(out_valid), 1);
          chk("stall_tag", int'(out_tag), 0);
          chk("stall_in_ready", int'(in_ready), 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          chk("stream_valid", int'(out_valid), 1);
          chk("stream_tag", int'(out_tag), k);
        end
      end
    join
    idle(4);

    // Flush with two in flight; the next result must be the post-flush pair.
    put(8'h22, 8'h11, 4'h1);
    put(8'h33, 8'h11, 4'h2);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    put(8'h07, 8'h03, 4'hA);
    g = 0;
    while (!out_valid && g < 10) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("flush_next_tag", int'(out_tag), 10);
    chk("flush_next_lz", int'(out_lz), 5);
    idle(3);

    // Reset with three in flight.
    put(8'h44, 8'h01, 4'h1);
    put(8'h45, 8'h02, 4'h2);
    put(8'h46, 8'h03, 4'h3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    send_chk(8'h03, 8'h0C, 4'hC, 4, 1, 0);
    idle(2);

    // Random traffic with random backpressure.
    acc_cnt = 0;
    g = 0;
    while (acc_cnt < 10000 && g < 60000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 4) != 0) begin
        in_valid = 1'b1;
        in_a     = 8'($urandom);
        mode     = $urandom_range(0, 5);
        case (mode)
          0:       in_b = in_a;
          1:       in_b = in_a + 8'd1;
          2:       in_b = in_a - 8'd1;
          3:       in_b = in_a ^ (8'h01 << $urandom_range(0, 7));
          default: in_b = 8'($urandom);
        endcase
        in_tag = 4'($urandom);
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        acc_cnt++;
        in_valid = 1'b0;
      end
      g++;
    end
    chk("random_accepted", acc_cnt, 10000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    g = 0;
    while (busy && g < 20) begin
      @(posedge clk);
      #1;
      g++;
    end
    @(negedge clk);
    chk("drain_queue_empty", q.size(), 0);
    chk("drain_busy", int'(busy), 0);
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
